// File: rtl/jpeg_pkg.sv
// Shared JPEG front-end types and constants: component codes, block geometry,
// the packed YCbCr pixel word and small per-sample helpers.
package jpeg_pkg;

    localparam int unsigned BLK_DIM     = 8;
    localparam int unsigned LEVEL_SHIFT = 128;
    localparam int unsigned SAMPLE_W    = 8;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    typedef struct packed {
        logic [SAMPLE_W-1:0] y;
        logic [SAMPLE_W-1:0] cb;
        logic [SAMPLE_W-1:0] cr;
    } ycbcr_t;

    // Pick one component of a pixel; code 3 is never produced and maps to Cr.
    function automatic logic [SAMPLE_W-1:0] comp_select(input ycbcr_t p, input logic [1:0] comp);
        logic [SAMPLE_W-1:0] s;
        case (comp)
            COMP_Y:  s = p.y;
            COMP_CB: s = p.cb;
            default: s = p.cr;
        endcase
        return s;
    endfunction

    // Unsigned sample minus 128, as an 8-bit two's complement value.
    function automatic logic [SAMPLE_W-1:0] level_shift(input logic [SAMPLE_W-1:0] s);
        return s - SAMPLE_W'(LEVEL_SHIFT);
    endfunction

endpackage

// File: rtl/ycbcr_strip_blocker_strip_ram.sv
// One-strip pixel store: synchronous write port, combinational read port.
module strip_ram
    import jpeg_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  ycbcr_t            wdata,
    input  logic [ADDR_W-1:0] raddr,
    output ycbcr_t            rdata
);

    ycbcr_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ycbcr_strip_blocker.sv
// Collects an 8-row raster strip of YCbCr pixels, then replays it as
// level-shifted 8x8 blocks interleaved Y, Cb, Cr per block column.
module ycbcr_strip_blocker
    import jpeg_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_sample,
    output logic [1:0]  out_comp,
    output logic        out_first,
    output logic        out_last,
    output logic        out_strip_last
);

    localparam int unsigned DEPTH  = IMG_WIDTH * BLK_DIM;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W  = $clog2(BLK_DIM);
    localparam int unsigned NBX    = IMG_WIDTH / BLK_DIM;
    localparam int unsigned BX_W   = (NBX > 1) ? $clog2(NBX) : 1;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [BX_W-1:0]   bx_q, bx_d;
    logic [1:0]        comp_q, comp_d;
    logic [ROW_W-1:0]  r_q, r_d;
    logic [ROW_W-1:0]  c_q, c_d;
    logic              issued_q, issued_d;

    logic              in_ready_d;
    logic              out_valid_d;
    logic [7:0]        out_sample_d;
    logic [1:0]        out_comp_d;
    logic              out_first_d;
    logic              out_last_d;
    logic              out_strip_last_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    ycbcr_t            rd_pixel;

    logic              last_c, last_r, last_comp, last_bx;
    logic              blk_first, blk_last, strip_end;

    assign wr_addr = ADDR_W'(row_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(col_q);
    assign rd_addr = ADDR_W'(r_q) * ADDR_W'(IMG_WIDTH)
                   + ADDR_W'(bx_q) * ADDR_W'(BLK_DIM)
                   + ADDR_W'(c_q);

    assign last_c    = (c_q == ROW_W'(BLK_DIM - 1));
    assign last_r    = (r_q == ROW_W'(BLK_DIM - 1));
    assign last_comp = (comp_q == COMP_CR);
    assign last_bx   = (bx_q == BX_W'(NBX - 1));
    assign blk_first = (r_q == '0) && (c_q == '0);
    assign blk_last  = last_r && last_c;
    assign strip_end = blk_last && last_comp && last_bx;

    strip_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_strip_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (ycbcr_t'(in_pixel)),
        .raddr (rd_addr),
        .rdata (rd_pixel)
    );

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d          = state_q;
        row_d            = row_q;
        col_d            = col_q;
        bx_d             = bx_q;
        comp_d           = comp_q;
        r_d              = r_q;
        c_d              = c_q;
        issued_d         = issued_q;
        wr_en            = 1'b0;
        out_valid_d      = out_valid;
        out_sample_d     = out_sample;
        out_comp_d       = out_comp;
        out_first_d      = out_first;
        out_last_d       = out_last;
        out_strip_last_d = out_strip_last;

        case (state_q)
            ST_FILL: begin
                if (in_valid && in_ready) begin
                    wr_en = 1'b1;
                    if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(BLK_DIM - 1)) begin
                            row_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (out_valid && out_ready && out_strip_last) begin
                    state_d     = ST_FILL;
                    out_valid_d = 1'b0;
                    issued_d    = 1'b0;
                    bx_d        = '0;
                    comp_d      = COMP_Y;
                    r_d         = '0;
                    c_d         = '0;
                    row_d       = '0;
                    col_d       = '0;
                end else if (!issued_q && (!out_valid || out_ready)) begin
                    out_valid_d      = 1'b1;
                    out_sample_d     = level_shift(comp_select(rd_pixel, comp_q));
                    out_comp_d       = comp_q;
                    out_first_d      = blk_first;
                    out_last_d       = blk_last;
                    out_strip_last_d = strip_end;
                    // Stop issuing once the final sample is parked in the output register.
                    issued_d         = strip_end;

                    // c innermost, then r, then component, then block column.
                    c_d = last_c ? '0 : c_q + ROW_W'(1);
                    if (last_c) begin
                        r_d = last_r ? '0 : r_q + ROW_W'(1);
                        if (last_r) begin
                            comp_d = last_comp ? COMP_Y : comp_q + 2'd1;
                            if (last_comp) begin
                                bx_d = last_bx ? '0 : bx_q + BX_W'(1);
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase

        in_ready_d = (state_d == ST_FILL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_FILL;
            row_q          <= '0;
            col_q          <= '0;
            bx_q           <= '0;
            comp_q         <= COMP_Y;
            r_q            <= '0;
            c_q            <= '0;
            issued_q       <= 1'b0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            out_sample     <= '0;
            out_comp       <= COMP_Y;
            out_first      <= 1'b0;
            out_last       <= 1'b0;
            out_strip_last <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            bx_q           <= bx_d;
            comp_q         <= comp_d;
            r_q            <= r_d;
            c_q            <= c_d;
            issued_q       <= issued_d;
            in_ready       <= in_ready_d;
            out_valid      <= out_valid_d;
            out_sample     <= out_sample_d;
            out_comp       <= out_comp_d;
            out_first      <= out_first_d;
            out_last       <= out_last_d;
            out_strip_last <= out_strip_last_d;
        end
    end

endmodule

// File: tb/tb_ycbcr_strip_blocker.sv
// Strip-level bench: table of strip scenarios, a block-order model feeding a
// scoreboard queue, plus reset, backpressure and drain-blocking sequences.
module tb_ycbcr_strip_blocker;

    localparam int W       = 16;
    localparam int NPIX    = W * 8;
    localparam int NSAMP   = 3 * 8 * W;
    localparam int NVEC    = 5;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_pixel;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sample;
    logic [1:0]  out_comp;
    logic        out_first;
    logic        out_last;
    logic        out_strip_last;

    typedef struct packed {
        logic [7:0] sample;
        logic [1:0] comp;
        logic       first;
        logic       last;
        logic       slast;
    } exp_t;

    typedef struct {
        int         off;
        logic [7:0] cb;
        logic [7:0] cr;
        bit         bp;
        bit         hold;
        int         stop;
        logic [7:0] e_y00;
        logic [7:0] e_y77;
        logic [7:0] e_b1;
        logic [7:0] e_cb;
        logic [7:0] e_cr;
    } vec_t;

    exp_t q[$];
    vec_t vecs[NVEC];
    int   errors = 0;
    int   checks = 0;

    ycbcr_strip_blocker #(.IMG_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pixel       (in_pixel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sample     (out_sample),
        .out_comp       (out_comp),
        .out_first      (out_first),
        .out_last       (out_last),
        .out_strip_last (out_strip_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected block-ordered stream for one strip.
    task automatic push_model(input vec_t v);
        exp_t       e;
        logic [7:0] val;
        for (int bx = 0; bx < W / 8; bx++)
            for (int cp = 0; cp < 3; cp++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        if (cp == 0)      val = 8'(r * W + bx * 8 + c + v.off);
                        else if (cp == 1) val = v.cb;
                        else              val = v.cr;
                        e.sample = 8'(int'(val) - 128);
                        e.comp   = 2'(cp);
                        e.first  = (r == 0) && (c == 0);
                        e.last   = (r == 7) && (c == 7);
                        e.slast  = e.last && (cp == 2) && (bx == W / 8 - 1);
                        q.push_back(e);
                    end
    endtask

    task automatic run_strip(input vec_t v);
        int        idx;
        int        cyc;
        bit        done;
        bit        stall;
        exp_t      e;
        logic [12:0] saved;

        push_model(v);
        for (int i = 0; i < NPIX; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_pixel = {8'(i + v.off), v.cb, v.cr};
            if (i == 0) begin
                @(negedge clk);
                check("fill_in_ready", 32'(in_ready), 32'd1);
            end
        end
        @(posedge clk); #1;
        in_valid = v.hold;
        in_pixel = 24'hABCDEF;
        check("drain_in_ready_low", 32'(in_ready), 32'd0);
        check("valid_low_after_last_pixel", 32'(out_valid), 32'd0);

        idx = 0; cyc = 0; done = 1'b0; stall = 1'b0; saved = '0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
            @(negedge clk);
            if (cyc == 1) check("fill_to_drain_latency", 32'(out_valid), 32'd1);
            if (stall)
                check("stall_stable",
                      32'({out_valid, out_sample, out_comp, out_first, out_last, out_strip_last}),
                      32'({1'b1, saved}));
            if (v.hold) check("in_ready_blocked", 32'(in_ready), 32'd0);
            stall = out_valid && !out_ready;
            saved = {out_sample, out_comp, out_first, out_last, out_strip_last};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_sample: got sample %0d with empty scoreboard", idx);
                end else begin
                    e = q.pop_front();
                    check($sformatf("sample_%0d", idx),
                          32'({out_sample, out_comp, out_first, out_last, out_strip_last}),
                          32'(e));
                end
                case (idx)
                    0:   check("blk0_y_r0c0", 32'(out_sample), 32'(v.e_y00));
                    63:  check("blk0_y_r7c7", 32'(out_sample), 32'(v.e_y77));
                    64:  check("blk0_cb",     32'(out_sample), 32'(v.e_cb));
                    128: check("blk0_cr",     32'(out_sample), 32'(v.e_cr));
                    192: check("blk1_y_r0c0", 32'(out_sample), 32'(v.e_b1));
                    default: ;
                endcase
                if (out_strip_last) begin
                    check("strip_length", 32'(idx), 32'(NSAMP - 1));
                    done = 1'b1;
                end
                idx++;
                if (v.stop != 0 && idx == v.stop) done = 1'b1;
            end
        end

        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d samples expected %0d", idx, NSAMP);
            q.delete();
        end else if (v.stop == 0) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("refill_in_ready", 32'(in_ready), 32'd1);
            check("refill_valid_low", 32'(out_valid), 32'd0);
            check("scoreboard_empty", 32'(q.size()), 32'd0);
        end else begin
            // Reset in the middle of the low clock phase, with a sample pending.
            #2;
            rst = 1'b1;
            #1;
            check("midrst_valid", 32'(out_valid), 32'd0);
            check("midrst_in_ready", 32'(in_ready), 32'd1);
            check("midrst_flags", 32'({out_sample, out_comp, out_first, out_last, out_strip_last}), 32'd0);
            q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{off: 0, cb: 8'h80, cr: 8'hFF, bp: 1'b0, hold: 1'b0, stop: 0,
                    e_y00: 8'h80, e_y77: 8'hF7, e_b1: 8'h88, e_cb: 8'h00, e_cr: 8'h7F};
        vecs[1] = '{off: 0, cb: 8'h80, cr: 8'hFF, bp: 1'b1, hold: 1'b1, stop: 0,
                    e_y00: 8'h80, e_y77: 8'hF7, e_b1: 8'h88, e_cb: 8'h00, e_cr: 8'h7F};
        vecs[2] = '{off: 0, cb: 8'h80, cr: 8'hFF, bp: 1'b0, hold: 1'b0, stop: 100,
                    e_y00: 8'h80, e_y77: 8'hF7, e_b1: 8'h88, e_cb: 8'h00, e_cr: 8'h7F};
        vecs[3] = '{off: 0, cb: 8'h80, cr: 8'hFF, bp: 1'b0, hold: 1'b0, stop: 0,
                    e_y00: 8'h80, e_y77: 8'hF7, e_b1: 8'h88, e_cb: 8'h00, e_cr: 8'h7F};
        vecs[4] = '{off: 1, cb: 8'h00, cr: 8'h80, bp: 1'b0, hold: 1'b0, stop: 0,
                    e_y00: 8'h81, e_y77: 8'hF8, e_b1: 8'h89, e_cb: 8'h80, e_cr: 8'h00};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'({out_sample, out_comp, out_first, out_last, out_strip_last}), 32'd0);
        #20;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_strip(vecs[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
